// File: rtl/functional_unit_core.sv
// ============================================================================
// functional_unit_core -- single-cycle 16-opcode ALU with registered result F.
// Optional macro SAT_ARITH_EN: ADD and A+B+C saturate high, SUB saturates at 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module functional_unit_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       instruction,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [2:0]       select,
  output logic [WIDTH-1:0] F
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_ROTL = 4'd8;
  localparam logic [3:0] OP_MAX  = 4'd9;
  localparam logic [3:0] OP_MIN  = 4'd10;
  localparam logic [3:0] OP_ABSD = 4'd11;
  localparam logic [3:0] OP_ADD3 = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_POPC = 4'd14;
  localparam logic [3:0] OP_PASS = 4'd15;

  logic [3:0]       opcode;
  logic [3:0]       imm;
  logic [2:0]       shamt;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] add3_res;
  logic [WIDTH-1:0] rotl_res;
  logic [WIDTH-1:0] popc_res;
  logic [WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] result;

  assign opcode  = instruction[7:4];
  assign imm     = instruction[3:0];
  assign shamt   = imm[2:0];
  assign imm_ext = {{(WIDTH-4){1'b0}}, imm};

  always_comb begin
    x = A;
    y = B;
    case (select)
      3'd0: begin x = A; y = B;       end
      3'd1: begin x = A; y = C;       end
      3'd2: begin x = B; y = C;       end
      3'd3: begin x = B; y = A;       end
      3'd4: begin x = C; y = A;       end
      3'd5: begin x = C; y = B;       end
      3'd6: begin x = A; y = imm_ext; end
      default: begin x = C; y = imm_ext; end
    endcase
  end

`ifdef SAT_ARITH_EN
  logic [WIDTH:0]   add_full;
  logic [WIDTH+1:0] add3_full;

  assign add_full  = {1'b0, x} + {1'b0, y};
  assign add3_full = {2'b00, A} + {2'b00, B} + {2'b00, C};
  assign add_res   = add_full[WIDTH] ? {WIDTH{1'b1}} : add_full[WIDTH-1:0];
  assign sub_res   = (x < y) ? '0 : x - y;
  assign add3_res  = (add3_full[WIDTH+1:WIDTH] != 2'b00) ? {WIDTH{1'b1}}
                                                          : add3_full[WIDTH-1:0];
`else
  assign add_res  = x + y;
  assign sub_res  = x - y;
  assign add3_res = A + B + C;
`endif

  // Bits shifted out the top re-enter at the bottom; a zero amount shifts by WIDTH, yielding 0.
  assign rotl_res = (x << shamt) | (x >> (WIDTH - int'(shamt)));
  assign mul_res  = x * y;

  always_comb begin
    popc_res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popc_res = popc_res + {{(WIDTH-1){1'b0}}, x[i]};
    end
  end

  always_comb begin
    result = x;
    case (opcode)
      OP_ADD:  result = add_res;
      OP_SUB:  result = sub_res;
      OP_AND:  result = x & y;
      OP_OR:   result = x | y;
      OP_XOR:  result = x ^ y;
      OP_NOT:  result = ~x;
      OP_SHL:  result = x << shamt;
      OP_SHR:  result = x >> shamt;
      OP_ROTL: result = rotl_res;
      OP_MAX:  result = (y > x) ? y : x;
      OP_MIN:  result = (y < x) ? y : x;
      OP_ABSD: result = (x >= y) ? (x - y) : (y - x);
      OP_ADD3: result = add3_res;
      OP_MUL:  result = mul_res;
      OP_POPC: result = popc_res;
      OP_PASS: result = x;
      default: result = x;
    endcase
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      F <= '0;
    end else begin
      F <= result;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_functional_unit_core.sv
// ============================================================================
// tb_functional_unit_core -- directed vectors with a queue-based scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_functional_unit_core;

  logic       clk;
  logic       rst_n;
  logic [7:0] instruction;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] C;
  logic [2:0] select;
  logic [7:0] F;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  functional_unit_core #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .A           (A),
    .B           (B),
    .C           (C),
    .select      (select),
    .F           (F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SAT_ARITH_EN
  localparam logic [7:0] E_ADD_FF = 8'hFF;
  localparam logic [7:0] E_SUB_59 = 8'h00;
  localparam logic [7:0] E_ADD3   = 8'hFF;
`else
  localparam logic [7:0] E_ADD_FF = 8'hFE;
  localparam logic [7:0] E_SUB_59 = 8'hFC;
  localparam logic [7:0] E_ADD3   = 8'h01;
`endif

  // Inputs change on the falling edge; the result of each vector is due one rising edge later.
  task automatic apply(input logic rst, input logic [7:0] ins, input logic [2:0] sel,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    rst_n       = rst;
    instruction = ins;
    select      = sel;
    A           = a;
    B           = b;
    C           = c;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (F !== e.exp) begin
        failures++;
        $display("FAIL %s: F=%h expected=%h", e.name, F, e.exp);
      end
    end
  end

  initial begin
    rst_n = 1'b1; instruction = 8'h00; select = 3'd0;
    A = 8'hFF; B = 8'hFF; C = 8'h00;

    apply(1, 8'h00, 3'd0, 8'hFF, 8'hFF, 8'h00, 8'h00,   "reset_clears");
    apply(0, 8'h00, 3'd0, 8'hFF, 8'hFF, 8'h00, E_ADD_FF, "add_after_release");
    apply(0, 8'h01, 3'd1, 8'h10, 8'h00, 8'h20, 8'h30,   "add_sel1");
    apply(0, 8'h05, 3'd7, 8'h00, 8'h00, 8'h20, 8'h25,   "add_sel7_imm");
    apply(0, 8'h10, 3'd0, 8'h05, 8'h09, 8'h00, E_SUB_59, "sub_underflow");
    apply(0, 8'h10, 3'd3, 8'h05, 8'h09, 8'h00, 8'h04,   "sub_sel3");
    apply(0, 8'h20, 3'd0, 8'hF0, 8'h3C, 8'h00, 8'h30,   "and");
    apply(0, 8'h30, 3'd0, 8'hF0, 8'h3C, 8'h00, 8'hFC,   "or");
    apply(0, 8'h40, 3'd0, 8'hF0, 8'h3C, 8'h00, 8'hCC,   "xor");
    apply(0, 8'h50, 3'd0, 8'hF0, 8'h3C, 8'h00, 8'h0F,   "not");
    apply(0, 8'h63, 3'd6, 8'h81, 8'h00, 8'h00, 8'h08,   "shl3");
    apply(0, 8'h6C, 3'd6, 8'h81, 8'h00, 8'h00, 8'h10,   "shl_imm3_ignored");
    apply(0, 8'h83, 3'd6, 8'h81, 8'h00, 8'h00, 8'h0C,   "rotl3");
    apply(0, 8'h80, 3'd0, 8'h81, 8'h00, 8'h00, 8'h81,   "rotl0");
    apply(0, 8'h7B, 3'd6, 8'h81, 8'h00, 8'h00, 8'h10,   "shr_imm3_ignored");
    apply(0, 8'h90, 3'd1, 8'h30, 8'h00, 8'h50, 8'h50,   "max");
    apply(0, 8'hA0, 3'd1, 8'h30, 8'h00, 8'h50, 8'h30,   "min");
    apply(0, 8'hB0, 3'd1, 8'h30, 8'h00, 8'h50, 8'h20,   "absdiff");
    apply(0, 8'hB0, 3'd3, 8'h30, 8'h90, 8'h00, 8'h60,   "absdiff_xgty");
    apply(0, 8'h90, 3'd0, 8'h42, 8'h42, 8'h00, 8'h42,   "max_equal");
    apply(0, 8'hC0, 3'd5, 8'h80, 8'h80, 8'h01, E_ADD3,  "add3_sel5");
    apply(0, 8'hC0, 3'd2, 8'h80, 8'h80, 8'h01, E_ADD3,  "add3_sel2");
    apply(0, 8'hC0, 3'd0, 8'h11, 8'h22, 8'h33, 8'h66,   "add3_small");
    apply(0, 8'hE0, 3'd0, 8'hB7, 8'h00, 8'h00, 8'h06,   "popcount");
    apply(0, 8'hD0, 3'd2, 8'h00, 8'h10, 8'h11, 8'h10,   "mul_low");
    apply(0, 8'hF0, 3'd4, 8'h00, 8'h10, 8'h11, 8'h11,   "pass_c");
    apply(1, 8'h00, 3'd0, 8'h01, 8'h01, 8'h00, 8'h00,   "reset_midstream");
    apply(0, 8'hF0, 3'd0, 8'h5A, 8'h00, 8'h00, 8'h5A,   "pass_after_reset");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/functional_unit_core.md
FUNCTIONAL_UNIT_CORE -- requirements
Module: Functional_Unit

Interface
REQ-001 Parameter: WIDTH, default 8, data width of A, B, C and F; the verified configuration is WIDTH=8.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  reset, synchronous and active-high despite the name; clears F on the clock edge where it is sampled 1.
REQ-004 instruction  input  8  bits[7:4] opcode, bits[3:0] immediate IMM.
REQ-005 A  input  WIDTH  operand A, unsigned.
REQ-006 B  input  WIDTH  operand B, unsigned.
REQ-007 C  input  WIDTH  operand C, unsigned.
REQ-008 select  input  3  operand-routing code.
REQ-009 F  output  WIDTH  registered result.

Function
REQ-010 Operand routing SHALL be combinational on select, giving X,Y: 0:A,B; 1:A,C; 2:B,C; 3:B,A; 4:C,A; 5:C,B; 6:A,{0,IMM}; 7:C,{0,IMM}.
REQ-011 Opcodes SHALL compute R: 0 ADD X+Y; 1 SUB X-Y; 2 AND; 3 OR; 4 XOR; 5 NOT X; 6 SHL X by IMM[2:0]; 7 SHR logical X by IMM[2:0]; 8 ROTL X by IMM[2:0]; 9 MAX(X,Y); 10 MIN(X,Y); 11 |X-Y|; 12 A+B+C; 13 low 8 bits of X*Y; 14 popcount(X); 15 pass X.
REQ-012 All operands and comparisons SHALL be unsigned.
REQ-013 Without SAT_ARITH_EN, ADD, SUB and opcode 12 SHALL wrap modulo 2^WIDTH.
REQ-014 Opcode 12 SHALL ignore select.
REQ-015 For opcodes 6–8, IMM[3] SHALL be ignored.
REQ-016 MAX and MIN SHALL return X when X equals Y.
REQ-017 Popcount SHALL be zero-extended to WIDTH.
REQ-018 F SHALL load R on every rising clk edge where rst_n=0.
REQ-019 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on F after edge N.
REQ-020 There is no handshake or enable; a new operation is accepted every cycle.
REQ-021 The block has no state other than F.
REQ-022 F SHALL never be X or Z after the first reset edge; all 16 opcodes × 8 selects are defined.

Reset
REQ-023 When rst_n=1 at a clk edge, F SHALL become 0 regardless of the other inputs.
REQ-024 Reset SHALL take priority over computation.
REQ-025 On the first edge after rst_n returns to 0, F SHALL hold the result of the inputs present at that edge.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight result.

Configuration
REQ-027 Macro SAT_ARITH_EN defined: ADD and opcode 12 SHALL saturate at 2^WIDTH-1, and SUB SHALL saturate at 0.
REQ-028 Macro SAT_ARITH_EN undefined: wrap-around per REQ-013; all other opcodes are identical in both builds.

Verification
REQ-029 rst_n=1 with A=FF, B=FF, opcode 0 -> F=00; release rst_n, next edge -> F=FE (wrap) or FF (SAT_ARITH_EN).
REQ-030 instruction=8'h1_0, select=0, A=05, B=09 -> F=FC (wrap) or 00 (SAT_ARITH_EN); select=3 -> F=04.
REQ-031 instruction=8'h6_3, select=6, A=81 -> F=08; instruction=8'h8_3 -> F=0C; instruction=8'h7_B -> F=10.
REQ-032 instruction=8'h9_0 / 8'hA_0 / 8'hB_0, select=1, A=30, C=50 -> F=50 / 30 / 20 on successive edges (back-to-back ops, 1-cycle latency).
REQ-033 instruction=8'hC_0, A=80, B=80, C=01, any select -> F=01 (wrap) or FF (SAT_ARITH_EN); instruction=8'hE_0, select=0, A=B7 -> F=06.
REQ-034 instruction=8'hD_0, select=2, B=10, C=11 -> F=10; instruction=8'hF_0, select=4 -> F=C.
